// File: rtl/ball_pair_collision_scanner.sv
// ball_pair_collision_scanner: per-frame pairwise ball overlap scan, publishes the first non-suppressed pair.
// Optional macro COLLISION_COUNT_EN adds a saturating col_count output of published hits.
module ball_pair_collision_scanner #(
  parameter int NUM_BALLS       = 6,
  parameter int DIAMETER_SQ     = 1024,
  parameter int COOLDOWN_FRAMES = 4
) (
  input  logic                           clk,
  input  logic                           resetN,
  input  logic                           startOfFrame,
  input  logic signed [NUM_BALLS:0][10:0] topLeftX_VEC_in,
  input  logic signed [NUM_BALLS:0][10:0] topLeftY_VEC_in,
  output logic [NUM_BALLS:0]             balls_collide,
  output logic [1:0][3:0]                Balls_col_ID,
  output logic                           col_valid
`ifdef COLLISION_COUNT_EN
  ,
  output logic [15:0]                    col_count
`endif
);
  localparam int NB = NUM_BALLS + 1;
  localparam int IW = $clog2(NB);
  localparam int CW = $clog2(COOLDOWN_FRAMES + 1);
  typedef enum logic [1:0] {IDLE, SCAN, PUBLISH} state_t;
  state_t state, state_nx;
  logic [NUM_BALLS:0][10:0] sx, sy;
  logic [3:0] ci, cj, pi, pj, fi, fj, li, lj;
  logic sd, pv, found, hit;
  logic [22:0] psum;
  logic [CW-1:0] cool;
  logic signed [10:0] dx, dy;
  logic signed [21:0] qx, qy;
  always_comb begin
    dx = $signed(sx[ci[IW-1:0]]) - $signed(sx[cj[IW-1:0]]);
    dy = $signed(sy[ci[IW-1:0]]) - $signed(sy[cj[IW-1:0]]);
    qx = dx * dx;
    qy = dy * dy;
    hit = pv && (psum < 23'(DIAMETER_SQ)) && !(cool != '0 && pi == li && pj == lj);
  end
  always_comb begin
    state_nx = state;
    if (startOfFrame) state_nx = SCAN;
    else if (state == SCAN && sd) state_nx = PUBLISH;
    else if (state == PUBLISH) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) state <= IDLE;
    else state <= state_nx;
  // Two-stage scan: squares are registered, the compare/first-hit latch runs one clock later.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      sx <= '0;
      sy <= '0;
      ci <= '0;
      cj <= '0;
      pi <= '0;
      pj <= '0;
      fi <= '0;
      fj <= '0;
      li <= '0;
      lj <= '0;
      sd <= 1'b0;
      pv <= 1'b0;
      found <= 1'b0;
      psum <= '0;
      cool <= '0;
      balls_collide <= '0;
      Balls_col_ID <= '0;
      col_valid <= 1'b0;
`ifdef COLLISION_COUNT_EN
      col_count <= '0;
`endif
    end else if (startOfFrame) begin
      sx <= topLeftX_VEC_in;
      sy <= topLeftY_VEC_in;
      ci <= 4'd0;
      cj <= 4'd1;
      sd <= 1'b0;
      pv <= 1'b0;
      found <= 1'b0;
    end else if (state == SCAN) begin
      pv <= !sd;
      if (!sd) begin
        pi <= ci;
        pj <= cj;
        psum <= {1'b0, qx} + {1'b0, qy};
        sd <= (ci == 4'(NUM_BALLS - 1));
        ci <= (cj == 4'(NUM_BALLS)) ? ci + 4'd1 : ci;
        cj <= (cj == 4'(NUM_BALLS)) ? ci + 4'd2 : cj + 4'd1;
      end
      if (hit && !found) begin
        found <= 1'b1;
        fi <= pi;
        fj <= pj;
      end
    end else if (state == PUBLISH) begin
      balls_collide <= found ? (NB'(1) << fi) | (NB'(1) << fj) : '0;
      Balls_col_ID <= found ? {fj, fi} : '0;
      col_valid <= found;
      li <= found ? fi : li;
      lj <= found ? fj : lj;
      cool <= found ? CW'(COOLDOWN_FRAMES) : (cool != '0 ? cool - 1'b1 : cool);
`ifdef COLLISION_COUNT_EN
      col_count <= (found && col_count != 16'hFFFF) ? col_count + 16'd1 : col_count;
`endif
    end
  end
endmodule

// File: tb/tb_ball_pair_collision_scanner.sv
// tb_ball_pair_collision_scanner: directed checks of scan result, latency, threshold, cooldown and abort.
module tb_ball_pair_collision_scanner;
  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic sof = 1'b0;
  logic signed [6:0][10:0] xv, yv;
  logic [6:0] balls_collide;
  logic [1:0][3:0] Balls_col_ID;
  logic col_valid;
  logic [15:0] obs;
  int n_cmp = 0;
  int n_err = 0;
`ifdef COLLISION_COUNT_EN
  logic [15:0] col_count;
  logic [15:0] cnt0;
`endif
  localparam logic [15:0] NONE  = 16'h0000;
  localparam logic [15:0] HIT24 = {7'b0010100, 4'd4, 4'd2, 1'b1};
  localparam logic [15:0] HIT01 = {7'b0000011, 4'd1, 4'd0, 1'b1};
  localparam logic [15:0] HIT35 = {7'b0101000, 4'd5, 4'd3, 1'b1};
  localparam logic [15:0] HIT12 = {7'b0000110, 4'd2, 4'd1, 1'b1};

  ball_pair_collision_scanner dut (
    .clk(clk), .resetN(resetN), .startOfFrame(sof),
    .topLeftX_VEC_in(xv), .topLeftY_VEC_in(yv),
    .balls_collide(balls_collide), .Balls_col_ID(Balls_col_ID), .col_valid(col_valid)
`ifdef COLLISION_COUNT_EN
    , .col_count(col_count)
`endif
  );

  always #5 clk = ~clk;
  assign obs = {balls_collide, Balls_col_ID, col_valid};

  task automatic set_base();
    for (int k = 0; k < 7; k++) begin
      xv[k] = 11'(k * 150);
      yv[k] = 11'sd0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk) resetN = 1'b0;
    #3 resetN = 1'b1;
  endtask

  task automatic pulse();
    @(negedge clk) sof = 1'b1;
    @(negedge clk) sof = 1'b0;
  endtask

  task automatic frame(input string name, input logic [15:0] exp);
    pulse();
    repeat (23) @(posedge clk);
    #1;
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, obs, exp);
    end
  endtask

  task automatic test_hit();
    set_base();
    xv[2] = 11'sd100; yv[2] = 11'sd100;
    xv[4] = 11'sd120; yv[4] = 11'sd110;
    pulse();
    repeat (22) @(posedge clk);
    #1;
    n_cmp++;
    if (obs !== NONE) begin
      n_err++;
      $display("FAIL hit_early: got %h want %h", obs, NONE);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (obs !== HIT24) begin
      n_err++;
      $display("FAIL hit_24: got %h want %h", obs, HIT24);
    end
    repeat (10) @(posedge clk);
    #1;
    n_cmp++;
    if (obs !== HIT24) begin
      n_err++;
      $display("FAIL hit_hold: got %h want %h", obs, HIT24);
    end
  endtask

  task automatic test_reset();
    pulse();
    repeat (5) @(posedge clk);
    #2 resetN = 1'b0;
    #1;
    n_cmp++;
    if (obs !== NONE) begin
      n_err++;
      $display("FAIL reset_async: got %h want %h", obs, NONE);
    end
    @(negedge clk) resetN = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    n_cmp++;
    if (obs !== NONE) begin
      n_err++;
      $display("FAIL reset_idle: got %h want %h", obs, NONE);
    end
    frame("reset_cooldown_clear", HIT24);
  endtask

  task automatic test_threshold();
    do_reset();
    set_base();
    xv[0] = 11'sd50; yv[0] = 11'sd50;
    xv[1] = 11'sd82; yv[1] = 11'sd50;
    frame("thr_1024", NONE);
    xv[1] = 11'sd81;
    frame("thr_961", HIT01);
    xv[1] = 11'sd82;
    frame("thr_clear", NONE);
  endtask

  task automatic test_two_pairs();
    do_reset();
    set_base();
    xv[0] = 11'sd50; yv[0] = 11'sd50;
    xv[1] = 11'sd60; yv[1] = 11'sd50;
    xv[5] = 11'sd460;
    frame("pairs_n", HIT01);
    frame("pairs_n1", HIT35);
    frame("pairs_n2", HIT01);
  endtask

  task automatic test_cooldown();
    do_reset();
    set_base();
    xv[2] = 11'sd170;
    frame("cool_n", HIT12);
    for (int f = 1; f <= 4; f++) frame($sformatf("cool_n%0d", f), NONE);
    frame("cool_n5", HIT12);
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_base();
    xv[2] = 11'sd100; yv[2] = 11'sd100;
    xv[4] = 11'sd120; yv[4] = 11'sd110;
`ifdef COLLISION_COUNT_EN
    cnt0 = col_count;
`endif
    pulse();
    repeat (9) @(posedge clk);
    set_base();
    xv[2] = 11'sd170;
    pulse();
    repeat (22) @(posedge clk);
    #1;
    n_cmp++;
    if (obs !== NONE) begin
      n_err++;
      $display("FAIL abort_early: got %h want %h", obs, NONE);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (obs !== HIT12) begin
      n_err++;
      $display("FAIL abort_new: got %h want %h", obs, HIT12);
    end
`ifdef COLLISION_COUNT_EN
    n_cmp++;
    if (col_count !== cnt0 + 16'd1) begin
      n_err++;
      $display("FAIL abort_count: got %0d want %0d", col_count, cnt0 + 16'd1);
    end
`endif
  endtask

  initial begin
    set_base();
    #12 resetN = 1'b1;
    n_cmp++;
    if (obs !== NONE) begin
      n_err++;
      $display("FAIL reset_state: got %h want %h", obs, NONE);
    end
    test_hit();
    test_reset();
    test_threshold();
    test_two_pairs();
    test_cooldown();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
